alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: CC_REQ, default 0; index of the requester whose operations update the condition codes.
REQ-002 Clock and reset: clk, synchronous, active-high rst.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 r0_valid/r1_valid  input  1  requester 0/1 has an operation pending.
REQ-006 r0_ready/r1_ready  output  1  arbiter accepts that requester's operation this cycle.
REQ-007 r0_fn/r1_fn  input  4  Y86 ALU function: 0 add, 1 sub, 2 and, 3 xor.
REQ-008 r0_a/r1_a, r0_b/r1_b  input  64  operands (valA, valB).
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 rsp_id  output  1  requester that owns the result.
REQ-012 rsp_data  output  64  result.
REQ-013 rsp_err  output  1  fn was greater than 3.
REQ-014 cc  output  3  {ZF,SF,OF} condition code register.

Function
REQ-015 FSM states IDLE, EXEC, RESP; IDLE -> EXEC on accept, EXEC -> RESP unconditionally, RESP -> IDLE on rsp_valid&rsp_ready.
REQ-016 rX_ready is high only in IDLE and only for the granted requester; at most one ready high per cycle.
REQ-017 Round robin: if both valid, grant the requester not granted last; if one valid, grant it; pointer updates only on accept.
REQ-018 On accept, fn, a, b and requester id are latched; later changes on request inputs have no effect.
REQ-019 In EXEC, result = b OP a (sub gives b - a), computed at 64 bits modulo 2^64, registered into rsp_data.
REQ-020 Latency: accept in cycle N gives rsp_valid high in cycle N+2.
REQ-021 rsp_valid, rsp_id, rsp_data, rsp_err hold stable in RESP until the handshake.
REQ-022 fn greater than 3 gives rsp_data 0 and rsp_err 1, and cc is unchanged.
REQ-023 OF: add, a and b same sign and result sign differs; sub, a and b signs differ and result sign differs from b; and/xor, 0.
REQ-024 cc updates at the EXEC-to-RESP edge, only for valid fn from requester CC_REQ.
REQ-025 Minimum spacing between accepts is 3 cycles; back-to-back with rsp_ready tied high gives one accept every 3 cycles.

Reset
REQ-026 rst gives state IDLE, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0, cc 3'b100 (ZF set), and the round-robin pointer favouring requester 0.
REQ-027 rst asserted in EXEC or RESP discards the in-flight operation with no response produced.

Configuration
REQ-028 ALU_ARBITER_CC_EN defined: cc register is implemented per REQ-024.
REQ-029 Macro undefined: cc is driven constant 3'b000 and no flag logic is synthesized.

Structure
REQ-030 Shared package alu_pkg holds the fn encodings (ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_XOR=3), state encodings and CC bit positions.
REQ-031 Sub-module alu_64: combinational 64-bit add/sub/and/xor with flag outputs, instanced once.

Verification
REQ-032 r0 add a=1, b=2, only r0 valid -> cycle N+2: rsp_data=3, rsp_id=0, cc=000.
REQ-033 r0 sub a=5, b=5 -> rsp_data=0, cc ZF=1; r1 sub with CC_REQ=0 -> cc unchanged.
REQ-034 r0 add a=b=64'h7FFF_FFFF_FFFF_FFFF -> rsp_data=64'hFFFF_FFFF_FFFF_FFFE, cc=011.
REQ-035 Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1, one accept every 3 cycles.
REQ-036 rsp_ready=0 for 5 cycles in RESP -> outputs stable, no rX_ready asserted; fn=7 -> rsp_err=1, rsp_data=0.
REQ-037 rst pulsed in EXEC -> next cycle IDLE, rsp_valid=0, cc=100, and requester 0 is granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the Y86-style ALU arbiter: function codes, FSM state
// encodings, condition-code bit positions and the latched-operation record.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // cc is packed as {ZF, SF, OF}
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

  typedef struct packed {
    logic        id;
    logic [3:0]  fn;
    logic [63:0] a;
    logic [63:0] b;
  } alu_op_t;

  function automatic logic fn_valid(input logic [3:0] fn);
    return (fn <= ALU_XOR);
  endfunction

endpackage

// File: rtl/alu_64.sv
// Combinational 64-bit add/sub/and/xor. b is the left operand (sub gives b - a).
// Flags are only generated when FLAG_EN is set; otherwise they are tied to zero.
module alu_64
  import alu_pkg::*;
#(
  parameter bit FLAG_EN = 1'b1
) (
  input  logic [3:0]  fn,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] y,
  output logic        err,
  output logic [2:0]  flags
);

  // Result select; an illegal function code yields zero and raises err.
  always_comb begin
    y   = 64'd0;
    err = ~fn_valid(fn);
    case (fn)
      ALU_ADD: y = b + a;
      ALU_SUB: y = b - a;
      ALU_AND: y = b & a;
      ALU_XOR: y = b ^ a;
      default: y = 64'd0;
    endcase
  end

  generate
    if (FLAG_EN) begin : g_flags
      logic ovf;

      // Signed overflow, judged on operand and result sign bits.
      always_comb begin
        ovf = 1'b0;
        case (fn)
          ALU_ADD: ovf = (a[63] == b[63]) && (y[63] != a[63]);
          ALU_SUB: ovf = (a[63] != b[63]) && (y[63] != b[63]);
          default: ovf = 1'b0;
        endcase
      end

      assign flags[CC_ZF] = (y == 64'd0);
      assign flags[CC_SF] = y[63];
      assign flags[CC_OF] = ovf;
    end else begin : g_no_flags
      assign flags = 3'b000;
    end
  endgenerate

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared 64-bit ALU (IDLE/EXEC/RESP).
// Define ALU_ARBITER_CC_EN to implement the {ZF,SF,OF} condition-code register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int CC_REQ = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [3:0]  r0_fn,
  input  logic [63:0] r0_a,
  input  logic [63:0] r0_b,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [3:0]  r1_fn,
  input  logic [63:0] r1_a,
  input  logic [63:0] r1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic [2:0]  cc
);

  logic [1:0]  state_r;
  logic        last_r;
  alu_op_t     op_r;
  logic        grant_s;
  logic        accept_s;
  alu_op_t     req_op_s;
  logic [63:0] alu_y_s;
  logic        alu_err_s;
  logic [2:0]  alu_flags_s;

  // Grant selection: alternate under contention, otherwise serve whoever asks.
  always_comb begin
    grant_s = 1'b0;
    if (r0_valid && r1_valid) begin
      grant_s = ~last_r;
    end else if (r1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    accept_s = (state_r == ST_IDLE) && (r0_valid || r1_valid);
    r0_ready = accept_s && !grant_s;
    r1_ready = accept_s && grant_s;
    if (grant_s) begin
      req_op_s = '{id: 1'b1, fn: r1_fn, a: r1_a, b: r1_b};
    end else begin
      req_op_s = '{id: 1'b0, fn: r0_fn, a: r0_a, b: r0_b};
    end
  end

  alu_64 #(
`ifdef ALU_ARBITER_CC_EN
    .FLAG_EN(1'b1)
`else
    .FLAG_EN(1'b0)
`endif
  ) u_alu (
    .fn    (op_r.fn),
    .a     (op_r.a),
    .b     (op_r.b),
    .y     (alu_y_s),
    .err   (alu_err_s),
    .flags (alu_flags_s)
  );

  // Control FSM; the operation is captured on accept so request inputs are free afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      last_r    <= 1'b1;
      op_r      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 64'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r    <= req_op_s;
            last_r  <= grant_s;
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= op_r.id;
          rsp_data  <= alu_y_s;
          rsp_err   <= alu_err_s;
          state_r   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARBITER_CC_EN
  localparam logic CC_OWNER = 1'(CC_REQ);
  logic [2:0] cc_r;

  // Flags follow only legal operations from the designated requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_r <= CC_RESET;
    end else if ((state_r == ST_EXEC) && !alu_err_s && (op_r.id == CC_OWNER)) begin
      cc_r <= alu_flags_s;
    end
  end

  assign cc = cc_r;
`else
  assign cc = alu_flags_s;
`endif

endmodule
